// File: rtl/seg7_scan_controller.sv
// Four-digit seven-segment scan controller with frame-synchronous double-buffered loads.
// Optional leading-zero blanking output is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_controller #(
  parameter int CLK_DIV   = 100000,
  parameter int CNT_WIDTH = 17
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        LOAD,
  input  logic [15:0] DIGITS_IN,
  input  logic [3:0]  DOTS_IN,
  output logic [1:0]  SEG_SELECT_OUT,
  output logic [3:0]  BIN_OUT,
  output logic        DOT_OUT,
  output logic        LOAD_ACK,
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  output logic        FRAME_TICK,
  output logic        BLANK_OUT
`else
  output logic        FRAME_TICK
`endif
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] PRESC_LAST = CNT_WIDTH'(CLK_DIV - 1);

  logic [CNT_WIDTH-1:0] r_presc;
  logic [1:0]           r_idx;
  logic [15:0]          r_active;
  logic [3:0]           r_active_dots;
  logic [15:0]          r_shadow;
  logic [3:0]           r_shadow_dots;
  logic                 r_ack;
  logic                 r_frame;
  state_t               r_state;

  logic   w_presc_last;
  logic   w_tick;
  logic   w_wrap;
  state_t w_state_next;
  logic   w_shadow_we;
  logic   w_active_we;
  logic   w_active_from_in;
  logic   w_ack_next;

  assign w_presc_last = (r_presc == PRESC_LAST);
  assign w_tick       = ENABLE & w_presc_last;
  assign w_wrap       = w_tick & (r_idx == 2'd3);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
      r_frame <= 1'b0;
    end else begin
      if (ENABLE) begin
        r_presc <= w_presc_last ? '0 : r_presc + 1'b1;
      end
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end
      r_frame <= w_wrap;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A frozen display cannot tear, so a pending value transfers immediately while disabled.
  always_comb begin
    w_state_next     = r_state;
    w_shadow_we      = 1'b0;
    w_active_we      = 1'b0;
    w_active_from_in = 1'b0;
    w_ack_next       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (LOAD) begin
          if (w_wrap) begin
            w_active_we      = 1'b1;
            w_active_from_in = 1'b1;
            w_ack_next       = 1'b1;
          end else begin
            w_shadow_we  = 1'b1;
            w_state_next = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (!ENABLE || w_wrap) begin
          w_active_we      = 1'b1;
          w_active_from_in = LOAD;
          w_ack_next       = 1'b1;
          w_state_next     = ST_IDLE;
        end else if (LOAD) begin
          w_shadow_we = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_shadow      <= 16'h0000;
      r_shadow_dots <= 4'h0;
      r_active      <= 16'h0000;
      r_active_dots <= 4'h0;
      r_ack         <= 1'b0;
    end else begin
      if (w_shadow_we) begin
        r_shadow      <= DIGITS_IN;
        r_shadow_dots <= DOTS_IN;
      end
      if (w_active_we) begin
        r_active      <= w_active_from_in ? DIGITS_IN : r_shadow;
        r_active_dots <= w_active_from_in ? DOTS_IN : r_shadow_dots;
      end
      r_ack <= w_ack_next;
    end
  end

  assign SEG_SELECT_OUT = r_idx;
  assign BIN_OUT        = r_active[{r_idx, 2'b00} +: 4];
  assign DOT_OUT        = r_active_dots[r_idx];
  assign LOAD_ACK       = r_ack;
  assign FRAME_TICK     = r_frame;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [3:0] w_digit_zero;
  logic [3:0] w_lead_zero;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_zero
      assign w_digit_zero[gi] = (r_active[4*gi +: 4] == 4'h0) & ~r_active_dots[gi];
    end
    // A digit is a leading zero only if it and every more significant digit are empty.
    for (gi = 0; gi < 3; gi++) begin : g_lead
      assign w_lead_zero[gi] = w_digit_zero[gi] & w_lead_zero[gi+1];
    end
  endgenerate
  assign w_lead_zero[3] = w_digit_zero[3];

  assign BLANK_OUT = (r_idx != 2'd0) & w_lead_zero[r_idx];
`endif

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Randomized and directed bench for seg7_scan_controller (CLK_DIV=4) against a
// counter/queue-level reference model of the scan and double-buffered load rules.
module tb_seg7_scan_controller;

  localparam int CD = 4;
  localparam int CW = 3;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic        LOAD;
  logic [15:0] DIGITS_IN;
  logic [3:0]  DOTS_IN;
  logic [1:0]  SEG_SELECT_OUT;
  logic [3:0]  BIN_OUT;
  logic        DOT_OUT;
  logic        LOAD_ACK;
  logic        FRAME_TICK;

  seg7_scan_controller #(.CLK_DIV(CD), .CNT_WIDTH(CW)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .ENABLE         (ENABLE),
    .LOAD           (LOAD),
    .DIGITS_IN      (DIGITS_IN),
    .DOTS_IN        (DOTS_IN),
    .SEG_SELECT_OUT (SEG_SELECT_OUT),
    .BIN_OUT        (BIN_OUT),
    .DOT_OUT        (DOT_OUT),
    .LOAD_ACK       (LOAD_ACK),
    .FRAME_TICK     (FRAME_TICK)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: total enabled clocks drive the digit position arithmetically.
  int          m_e;
  logic [15:0] m_active, m_shadow;
  logic [3:0]  m_adots, m_sdots;
  bit          m_pend, m_ack, m_frame;

  wire [8:0] w_dut = {SEG_SELECT_OUT, BIN_OUT, DOT_OUT, LOAD_ACK, FRAME_TICK};

  function automatic int model_idx();
    return (m_e / CD) % 4;
  endfunction

  function automatic logic [8:0] model_out();
    int sel;
    logic [1:0] s2;
    sel = model_idx();
    s2  = sel[1:0];
    return {s2, m_active[sel*4 +: 4], m_adots[sel], m_ack, m_frame};
  endfunction

  task automatic model_reset();
    m_e = 0; m_active = '0; m_shadow = '0; m_adots = '0; m_sdots = '0;
    m_pend = 0; m_ack = 0; m_frame = 0;
  endtask

  task automatic cycle(input bit en, input bit ld, input logic [15:0] d, input logic [3:0] p);
    bit wrap;
    ENABLE = en; LOAD = ld; DIGITS_IN = d; DOTS_IN = p;
    @(posedge CLK);
    wrap  = en && (((m_e + 1) % (4 * CD)) == 0);
    m_ack = 0;
    if (m_pend) begin
      if (!en || wrap) begin
        m_active = ld ? d : m_shadow;
        m_adots  = ld ? p : m_sdots;
        m_pend   = 0;
        m_ack    = 1;
      end else if (ld) begin
        m_shadow = d; m_sdots = p;
      end
    end else if (ld) begin
      if (wrap) begin
        m_active = d; m_adots = p; m_ack = 1;
      end else begin
        m_shadow = d; m_sdots = p; m_pend = 1;
      end
    end
    m_frame = wrap;
    if (en) m_e++;
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; ENABLE = 1'b0; LOAD = 1'b0; DIGITS_IN = '0; DOTS_IN = '0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    checks++;
    if (w_dut !== 9'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", w_dut, 9'h000);
    end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_scan();
    int ticks = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(1, 0, '0, '0);
      checks++;
      if (w_dut !== model_out()) begin
        errors++;
        $display("FAIL scan: got %h expected %h", w_dut, model_out());
      end
      if (FRAME_TICK) ticks++;
    end
    checks++;
    if (ticks !== 2) begin
      errors++;
      $display("FAIL scan_frame_count: got %0d expected 2", ticks);
    end
    $display("scan: 32 cycles, %0d frame ticks", ticks);
  endtask

  task automatic test_load_mid_frame();
    int acks = 0;
    for (int k = 0; k < 64 && model_idx() != 1; k++) cycle(1, 0, '0, '0);
    checks++;
    if (model_idx() != 1) begin
      errors++;
      $display("FAIL load_mid_wait: got index %0d expected 1", model_idx());
    end
    cycle(1, 1, 16'hA5C3, 4'b0100);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (w_dut !== model_out()) begin
        errors++;
        $display("FAIL load_mid: got %h expected %h", w_dut, model_out());
      end
      if (LOAD_ACK) acks++;
      if (acks > 0 && SEG_SELECT_OUT == 2'd2) begin
        checks++;
        if ({BIN_OUT, DOT_OUT} !== {4'h5, 1'b1}) begin
          errors++;
          $display("FAIL load_mid_digit2: got %h/%b expected 5/1", BIN_OUT, DOT_OUT);
        end
      end
      cycle(1, 0, '0, '0);
    end
    checks++;
    if (acks !== 1) begin
      errors++;
      $display("FAIL load_mid_ack_count: got %0d expected 1", acks);
    end
    $display("load_mid_frame: A5C3 acks=%0d", acks);
  endtask

  task automatic test_double_load();
    int acks = 0;
    for (int k = 0; k < 64 && !(model_idx() == 0 && !m_frame && (m_e % CD) == 1); k++)
      cycle(1, 0, '0, '0);
    cycle(1, 1, 16'h1111, 4'h0);
    cycle(1, 0, '0, '0);
    cycle(1, 0, '0, '0);
    cycle(1, 1, 16'h2222, 4'h0);
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, '0, '0);
      checks++;
      if (w_dut !== model_out()) begin
        errors++;
        $display("FAIL double_load: got %h expected %h", w_dut, model_out());
      end
      if (LOAD_ACK) acks++;
      if (acks > 0) begin
        checks++;
        if (BIN_OUT !== 4'h2) begin
          errors++;
          $display("FAIL double_load_value: got %h expected 2", BIN_OUT);
        end
      end
    end
    checks++;
    if (acks !== 1) begin
      errors++;
      $display("FAIL double_load_ack_count: got %0d expected 1", acks);
    end
    $display("double_load: 1111 then 2222 acks=%0d", acks);
  endtask

  task automatic test_load_on_wrap();
    for (int k = 0; k < 64 && ((m_e + 1) % (4 * CD)) != 0; k++) cycle(1, 0, '0, '0);
    cycle(1, 1, 16'hBEEF, 4'h0);
    checks++;
    if ({SEG_SELECT_OUT, BIN_OUT, LOAD_ACK, FRAME_TICK} !== {2'd0, 4'hF, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL load_on_wrap: got sel=%0d bin=%h ack=%b ft=%b expected 0 F 1 1",
               SEG_SELECT_OUT, BIN_OUT, LOAD_ACK, FRAME_TICK);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, '0, '0);
      checks++;
      if (w_dut !== model_out()) begin
        errors++;
        $display("FAIL load_on_wrap_run: got %h expected %h", w_dut, model_out());
      end
    end
    $display("load_on_wrap: BEEF sel=%0d bin=%h", SEG_SELECT_OUT, BIN_OUT);
  endtask

  task automatic test_freeze();
    for (int k = 0; k < 64 && model_idx() != 2; k++) cycle(1, 0, '0, '0);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, '0, '0);
      checks++;
      if (SEG_SELECT_OUT !== 2'd2 || w_dut !== model_out()) begin
        errors++;
        $display("FAIL freeze_hold: got %h expected %h", w_dut, model_out());
      end
    end
    cycle(0, 1, 16'h0042, 4'h0);
    checks++;
    if (LOAD_ACK !== 1'b0) begin
      errors++;
      $display("FAIL freeze_load_early_ack: got %b expected 0", LOAD_ACK);
    end
    cycle(0, 0, '0, '0);
    checks++;
    if ({SEG_SELECT_OUT, BIN_OUT, LOAD_ACK} !== {2'd2, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL freeze_load_ack: got sel=%0d bin=%h ack=%b expected 2 0 1",
               SEG_SELECT_OUT, BIN_OUT, LOAD_ACK);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, '0, '0);
      checks++;
      if (w_dut !== model_out()) begin
        errors++;
        $display("FAIL freeze_resume: got %h expected %h", w_dut, model_out());
      end
    end
    $display("freeze: 0042 loaded while frozen, resumed at sel=%0d", SEG_SELECT_OUT);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      logic [15:0] d;
      logic [3:0]  p;
      d = 16'($urandom);
      p = 4'($urandom);
      cycle(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0), d, p);
      checks++;
      if (w_dut !== model_out()) begin
        errors++;
        bad++;
        $display("FAIL random_%0d: got %h expected %h", i, w_dut, model_out());
      end
    end
    $display("random: 400 cycles, %0d bad", bad);
  endtask

  task automatic test_async_reset_midframe();
    int acks = 0;
    repeat (5) cycle(1, 0, '0, '0);
    cycle(1, 1, 16'h9876, 4'hF);
    cycle(1, 0, '0, '0);
    #2;
    RESET = 1'b1;
    #1;
    model_reset();
    checks++;
    if (w_dut !== 9'h000) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", w_dut, 9'h000);
    end
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, '0, '0);
      checks++;
      if (w_dut !== model_out()) begin
        errors++;
        $display("FAIL async_reset_after: got %h expected %h", w_dut, model_out());
      end
      if (LOAD_ACK) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL async_reset_discard: got %0d acks expected 0", acks);
    end
    $display("async_reset_midframe: pending load discarded, acks=%0d", acks);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_load_mid_frame();
    test_double_load();
    test_load_on_wrap();
    test_freeze();
    test_random();
    test_async_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
- Time-multiplexed scan controller for the 4-digit seven-segment display path.
- Holds a 16-bit hex value plus 4 decimal points, and cycles a 2-bit digit select at a programmable refresh rate.
- Presents one 4-bit nibble and one dot per digit slot to the downstream hex/segment decoder.
- New values are double-buffered and applied only at frame boundaries, so the display never tears.

Parameters:
- CLK_DIV, 100000, clock cycles per digit slot (100 MHz gives 1 kHz digit rate, 250 Hz frame rate); legal range 1 to 2^CNT_WIDTH.
- CNT_WIDTH, 17, prescaler counter width; must satisfy 2^CNT_WIDTH >= CLK_DIV.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous reset, active-high.
- ENABLE  input  1  scan enable; low freezes the scan.
- LOAD  input  1  single-cycle strobe that captures DIGITS_IN and DOTS_IN.
- DIGITS_IN  input  16  four hex nibbles; [3:0] is digit 0 (rightmost).
- DOTS_IN  input  4  decimal points; bit n belongs to digit n.
- SEG_SELECT_OUT  output  2  current digit index, fed to the decoder select input.
- BIN_OUT  output  4  nibble of the current digit.
- DOT_OUT  output  1  dot of the current digit.
- LOAD_ACK  output  1  one-cycle pulse when captured data becomes active.
- FRAME_TICK  output  1  one-cycle pulse on the digit index wrap from 3 to 0.

Behaviour:
- Reset (asynchronous, RESET high):
  - prescaler=0, index=0, active value/dots=0, shadow value/dots=0, pending=0.
  - SEG_SELECT_OUT=0, BIN_OUT=0, DOT_OUT=0, LOAD_ACK=0, FRAME_TICK=0.
  - Reset asserted mid-frame or mid-load discards the shadow and pending state immediately.
- Prescaler:
  - While ENABLE=1: counts 0..CLK_DIV-1, wraps to 0, and raises the internal tick on the CLK_DIV-1 cycle.
  - CLK_DIV=1: tick on every cycle.
  - While ENABLE=0: prescaler and index hold their values.
- Index:
  - On tick: index <= index+1 mod 4.
  - On a tick with index=3: the next state is 0, and FRAME_TICK=1 for exactly that next cycle.
- Outputs:
  - SEG_SELECT_OUT = index register.
  - BIN_OUT = active[4*index+3 : 4*index]; DOT_OUT = active_dots[index].
  - All outputs are derived from registers only: no input-to-output combinational path.
  - The new nibble appears in the same cycle as the new index.
- Load / transfer state machine:
  - States: IDLE (pending=0) and PENDING (pending=1).
  - IDLE + LOAD: shadow <= inputs, go to PENDING.
  - PENDING + LOAD: shadow is overwritten (latest wins), stay in PENDING.
  - PENDING + wrap tick (index 3 to 0) with ENABLE=1: active <= shadow, return to IDLE, LOAD_ACK=1 for the next cycle.
  - LOAD in the same cycle as the transfer: DIGITS_IN/DOTS_IN are forwarded directly into active, go to IDLE, LOAD_ACK pulses.
  - PENDING with ENABLE=0: transfer occurs on the next clock (the display is frozen, so no tearing is possible) and LOAD_ACK pulses.
  - LOAD while ENABLE=0 and IDLE: capture, then transfer on the following clock.
- LOAD_ACK and FRAME_TICK never stay high for more than 1 cycle per event.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Adds output port BLANK_OUT (1 bit), registered with the same timing as BIN_OUT.
  - BLANK_OUT=1 when the current digit n (n=3..1) has nibble 0, dot 0, and all higher digits also have nibble 0 and dot 0.
  - Digit 0 is never blanked.
  - The top level gates the digit-select line with BLANK_OUT.
- Undefined: BLANK_OUT does not exist and every digit is always displayed.

Test Plan (CLK_DIV=4):
- Release RESET, ENABLE=1 -> outputs 0 at reset; SEG_SELECT_OUT steps 0,1,2,3,0 every 4 clocks; FRAME_TICK pulses once per 16 clocks.
- LOAD with DIGITS_IN=16'hA5C3, DOTS_IN=4'b0100 while index=1 -> display unchanged until the 3-to-0 wrap; then LOAD_ACK pulses once; digit slots show 3, C, 5+dot, A.
- Two LOADs (16'h1111, then 16'h2222) in the same frame -> only 2222 is displayed; exactly one LOAD_ACK.
- LOAD of 16'hBEEF coincident with the wrap tick -> BEEF is active from index 0 of the new frame; LOAD_ACK pulses next cycle.
- ENABLE=0 with index=2 for 20 clocks, then LOAD 16'h0042 -> index and BIN_OUT freeze; active=0042 and LOAD_ACK pulse one clock after the LOAD; scan resumes from index 2 on re-enable.
- With SEG7_LEADING_ZERO_BLANK_EN, value 16'h0042 and dots 0 -> BLANK_OUT=1 on digits 3 and 2 only; RESET asserted mid-frame clears all state asynchronously.
